instr_issue: RTL

INSTR_ISSUE -- requirements
Module: instr_issue

---
 rtl/instr_issue.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/instr_issue.sv
// In-order instruction issue stage: a program buffer and a small destination scoreboard.
// RAW hazards insert bubbles; all outputs are registered.
module instr_issue #(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned HAZ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_en,
    input  logic [4:0]  ld_addr,
    input  logic [23:0] ld_data,
    input  logic        start,
    input  logic [5:0]  prog_len,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic [3:0]  rd,
    output logic [3:0]  func,
    output logic [7:0]  addr,
    output logic        issue_valid,
    output logic        busy,
    output logic        done,
    output logic [7:0]  stall_cnt
);

    typedef enum logic [1:0] {StIdle, StIssue, StStall, StDone} state_e;

    state_e      state_q;
    logic [23:0] buf_q [DEPTH];
    logic [5:0]  pc_q;
    logic [5:0]  len_q;
    logic        sb_vld_q [HAZ_DEPTH];
    logic [3:0]  sb_rd_q [HAZ_DEPTH];

    logic [23:0] cur;
    logic        hazard;
    logic        halt;
    logic        last;
    logic        running;

    assign cur     = buf_q[pc_q[4:0]];
    assign halt    = (cur[23:20] == 4'hF);
    assign last    = ((pc_q + 6'd1) == len_q);
    assign running = (state_q == StIssue) || (state_q == StStall);

    // The oldest entry retires on this edge, so it can no longer block the candidate.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < int'(HAZ_DEPTH) - 1; i++) begin
            if (sb_vld_q[i] && ((sb_rd_q[i] == cur[15:12]) || (sb_rd_q[i] == cur[11:8]))) begin
                hazard = 1'b1;
            end
        end
    end

    // Buffer contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_en && !running) begin
            buf_q[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pc_q        <= 6'd0;
            len_q       <= 6'd0;
            for (int i = 0; i < int'(HAZ_DEPTH); i++) begin
                sb_vld_q[i] <= 1'b0;
                sb_rd_q[i]  <= 4'd0;
            end
            rs1         <= 4'd0;
            rs2         <= 4'd0;
            rd          <= 4'd0;
            func        <= 4'd0;
            addr        <= 8'd0;
            issue_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            stall_cnt   <= 8'd0;
        end else begin
            issue_valid <= 1'b0;
            done        <= 1'b0;
            if (running) begin
                for (int i = int'(HAZ_DEPTH) - 1; i > 0; i--) begin
                    sb_vld_q[i] <= sb_vld_q[i-1];
                    sb_rd_q[i]  <= sb_rd_q[i-1];
                end
                sb_vld_q[0] <= 1'b0;
                sb_rd_q[0]  <= cur[19:16];
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        pc_q      <= 6'd0;
                        stall_cnt <= 8'd0;
                        for (int i = 0; i < int'(HAZ_DEPTH); i++) begin
                            sb_vld_q[i] <= 1'b0;
                        end
                        if (prog_len == 6'd0) begin
                            len_q   <= 6'd0;
                            state_q <= StDone;
                        end else begin
                            len_q   <= (prog_len > 6'd32) ? 6'd32 : prog_len;
                            state_q <= StIssue;
                            busy    <= 1'b1;
                        end
                    end
                end
                StIssue, StStall: begin
                    if (state_q == StIssue && halt) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                    end else if (hazard) begin
                        state_q <= StStall;
                        if (stall_cnt != 8'hFF) begin
                            stall_cnt <= stall_cnt + 8'd1;
                        end
                    end else begin
                        func        <= cur[23:20];
                        rd          <= cur[19:16];
                        rs1         <= cur[15:12];
                        rs2         <= cur[11:8];
                        addr        <= cur[7:0];
                        issue_valid <= 1'b1;
                        sb_vld_q[0] <= 1'b1;
                        pc_q        <= pc_q + 6'd1;
                        if (last) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                        end else begin
                            state_q <= StIssue;
                        end
                    end
                end
                StDone: begin
                    done    <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
